// File: rtl/argmax_finder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : argmax_finder
// Purpose  : NN classifier output stage: serial argmax scan or threshold test.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_finder #(
    parameter int                     NUM_INPUT   = 10,
    parameter int                     INPUT_WIDTH = 16,
    parameter int                     SIGNED_CMP  = 0,
    parameter int                     MODE        = 0,
    parameter logic [INPUT_WIDTH-1:0] THRESHOLD   = 'h800
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [31:0]                      o_data,
    output logic [INPUT_WIDTH-1:0]           o_max_value,
    output logic                             o_data_valid
);

    localparam int                 c_CNT_W  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(NUM_INPUT - 1);
    localparam bit                 c_SERIAL = (MODE == 0) && (NUM_INPUT > 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_next_state;
    logic [INPUT_WIDTH-1:0] r_elem [NUM_INPUT];
    logic [c_CNT_W-1:0]     r_cnt;
    logic [INPUT_WIDTH-1:0] r_best_val;
    logic [c_CNT_W-1:0]     r_best_idx;
    logic [31:0]            r_data;
    logic [INPUT_WIDTH-1:0] r_max_value;
    logic                   r_data_valid;

    logic                   w_capture;
    logic [INPUT_WIDTH-1:0] w_elem0_in;
    logic [INPUT_WIDTH-1:0] w_cur;
    logic                   w_take;
    logic [INPUT_WIDTH-1:0] w_upd_val;
    logic [c_CNT_W-1:0]     w_upd_idx;
    logic                   w_thr_hit;

    function automatic logic f_gt(input logic [INPUT_WIDTH-1:0] a,
                                  input logic [INPUT_WIDTH-1:0] b);
        if (SIGNED_CMP != 0) begin
            f_gt = $signed(a) > $signed(b);
        end else begin
            f_gt = a > b;
        end
    endfunction

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_capture && c_SERIAL) w_next_state = S_SCAN;
            S_SCAN: if (r_cnt == c_LAST)       w_next_state = S_IDLE;
            default:                           w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready      = (r_state == S_IDLE);
        o_data       = r_data;
        o_max_value  = r_max_value;
        o_data_valid = r_data_valid;
    end

    assign w_capture  = i_valid && o_ready;
    assign w_elem0_in = i_data[INPUT_WIDTH-1:0];
    assign w_thr_hit  = f_gt(w_elem0_in, THRESHOLD);

    // Strict greater-than keeps the lower index on ties.
    always_comb begin
        w_cur     = r_elem[r_cnt];
        w_take    = f_gt(w_cur, r_best_val);
        w_upd_val = w_take ? w_cur : r_best_val;
        w_upd_idx = w_take ? r_cnt : r_best_idx;
    end

    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            for (int k = 0; k < NUM_INPUT; k++) begin
                r_elem[k] <= i_data[k*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_best_val   <= '0;
            r_best_idx   <= '0;
            r_data       <= '0;
            r_max_value  <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_capture) begin
                if (MODE != 0) begin
                    r_data       <= {31'd0, w_thr_hit};
                    r_max_value  <= w_elem0_in;
                    r_data_valid <= 1'b1;
                end else if (!c_SERIAL) begin
                    r_data       <= '0;
                    r_max_value  <= w_elem0_in;
                    r_data_valid <= 1'b1;
                end else begin
                    r_best_val <= w_elem0_in;
                    r_best_idx <= '0;
                    r_cnt      <= c_CNT_W'(1);
                end
            end
            if (r_state == S_SCAN) begin
                r_best_val <= w_upd_val;
                r_best_idx <= w_upd_idx;
                r_cnt      <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_data       <= 32'(w_upd_idx);
                    r_max_value  <= w_upd_val;
                    r_data_valid <= 1'b1;
                    r_cnt        <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_argmax_finder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_argmax_finder
// Purpose  : Self-checking bench for argmax_finder (unsigned, signed, thresh).
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_finder;

    localparam int N = 10;
    localparam int W = 16;

    typedef logic [W-1:0] vec_t [N];

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] d_data;
    logic           d_valid;
    logic [N*W-1:0] t_data;
    logic           t_valid;

    logic           a_ready, s_ready, t_ready;
    logic [31:0]    a_data, s_data, t_odata;
    logic [W-1:0]   a_max, s_max, t_max;
    logic           a_dv, s_dv, t_dv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    argmax_finder #(.NUM_INPUT(N), .INPUT_WIDTH(W), .SIGNED_CMP(0), .MODE(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(d_data), .i_valid(d_valid),
        .o_ready(a_ready), .o_data(a_data), .o_max_value(a_max), .o_data_valid(a_dv));

    argmax_finder #(.NUM_INPUT(N), .INPUT_WIDTH(W), .SIGNED_CMP(1), .MODE(0)) u_sgn (
        .i_clk(clk), .i_rst(rst), .i_data(d_data), .i_valid(d_valid),
        .o_ready(s_ready), .o_data(s_data), .o_max_value(s_max), .o_data_valid(s_dv));

    argmax_finder #(.NUM_INPUT(N), .INPUT_WIDTH(W), .SIGNED_CMP(0), .MODE(1),
                    .THRESHOLD(16'h0800)) u_thr (
        .i_clk(clk), .i_rst(rst), .i_data(t_data), .i_valid(t_valid),
        .o_ready(t_ready), .o_data(t_odata), .o_max_value(t_max), .o_data_valid(t_dv));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint key(input logic [W-1:0] x, input bit sgn);
        if (sgn) return longint'($signed(x));
        return longint'({1'b0, x});
    endfunction

    // First index holding the maximum value under the chosen ordering.
    function automatic int ref_idx(input vec_t v, input bit sgn);
        int best = 0;
        for (int k = 1; k < N; k++) begin
            if (key(v[k], sgn) > key(v[best], sgn)) best = k;
        end
        return best;
    endfunction

    task automatic load(input vec_t v);
        for (int k = 0; k < N; k++) d_data[k*W +: W] = v[k];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int ei;
        int es;
        ei = ref_idx(v, 1'b0);
        es = ref_idx(v, 1'b1);
        load(v);
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        n = 1;
        while (!a_dv && n < 3*N) begin
            check($sformatf("%s_busy", tag), {a_ready, a_dv}, 2'b00);
            step();
            n++;
        end
        check($sformatf("%s_latency", tag), n, N);
        check($sformatf("%s_idx", tag), a_data, ei);
        check($sformatf("%s_val", tag), a_max, v[ei]);
        check($sformatf("%s_ready", tag), a_ready, 1'b1);
        check($sformatf("%s_sdv", tag), s_dv, 1'b1);
        check($sformatf("%s_sidx", tag), s_data, es);
        check($sformatf("%s_sval", tag), s_max, v[es]);
        step();
        check($sformatf("%s_strobe1", tag), a_dv, 1'b0);
        check($sformatf("%s_hold", tag), a_data, ei);
    endtask

    initial begin
        vec_t v;
        vec_t vb;
        int   n;
        bit   any_dv;
        logic [W-1:0] x;

        rst = 1'b1; d_valid = 1'b0; t_valid = 1'b0; d_data = '0; t_data = '0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", a_ready, 1'b1);
        check("rst_data", a_data, 0);
        check("rst_max", a_max, 0);
        check("rst_dv", a_dv, 1'b0);
        check("rst_tready", t_ready, 1'b1);
        check("rst_tdv", t_dv, 1'b0);

        v = '{16'd3, 16'd9, 16'd1, 16'd4, 16'd2, 16'd8, 16'd0, 16'hFFF0, 16'd5, 16'd6};
        run_vec(v, "dir");
        check("dir_idx7", a_data, 7);
        check("dir_valFFF0", a_max, 16'hFFF0);

        for (int k = 0; k < N; k++) v[k] = 16'h0100;
        run_vec(v, "tie_all");
        check("tie_all_idx0", a_data, 0);

        for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 'h6FFF));
        v[2] = 16'h7000;
        v[6] = 16'h7000;
        run_vec(v, "tie_26");
        check("tie_26_idx2", a_data, 2);

        v = '{16'hFFFF, 16'h8000, 16'h0001, 16'hFFFE, 16'h8000,
              16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_vec(v, "sgn");
        check("sgn_s_idx2", s_data, 2);
        check("sgn_u_idx0", a_data, 0);
        check("sgn_u_valFFFF", a_max, 16'hFFFF);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                v[k] = (i % 2 == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
            end
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // i_valid held high across a scan with changing data
        for (int k = 0; k < N; k++) begin
            v[k]  = W'($urandom);
            vb[k] = W'($urandom);
        end
        load(v);
        d_valid = 1'b1;
        step();
        for (int e = 2; e <= N; e++) begin
            for (int k = 0; k < N; k++) d_data[k*W +: W] = W'($urandom);
            step();
        end
        check("b2b_a_dv", a_dv, 1'b1);
        check("b2b_a_idx", a_data, ref_idx(v, 1'b0));
        check("b2b_a_val", a_max, v[ref_idx(v, 1'b0)]);
        load(vb);
        step();
        d_valid = 1'b0;
        check("b2b_b_captured", a_ready, 1'b0);
        n = 1;
        while (!a_dv && n < 3*N) begin
            step();
            n++;
        end
        check("b2b_b_latency", n, N);
        check("b2b_b_idx", a_data, ref_idx(vb, 1'b0));
        check("b2b_b_sidx", s_data, ref_idx(vb, 1'b1));

        // Reset in the middle of a scan
        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        step();
        load(v);
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_ready", a_ready, 1'b1);
        check("mrst_data", a_data, 0);
        check("mrst_max", a_max, 0);
        check("mrst_dv", a_dv, 1'b0);
        check("mrst_sdata", s_data, 0);
        any_dv = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            step();
            any_dv = any_dv | a_dv | s_dv;
        end
        check("mrst_no_strobe", any_dv, 1'b0);
        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        run_vec(v, "post_rst");

        // Threshold mode
        t_data[W-1:0] = 16'h0801;
        t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        check("thr_801_dv", t_dv, 1'b1);
        check("thr_801_data", t_odata, 1);
        check("thr_801_max", t_max, 16'h0801);
        check("thr_801_ready", t_ready, 1'b1);
        step();
        check("thr_801_strobe1", t_dv, 1'b0);
        check("thr_801_hold", t_odata, 1);
        t_data[W-1:0] = 16'h0800;
        t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        check("thr_800_dv", t_dv, 1'b1);
        check("thr_800_data", t_odata, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            x = W'($urandom_range(0, 'h1000));
            if (i == 0) x = 16'hFFFF;
            t_data = {(N*W){1'b1}};
            t_data[W-1:0] = x;
            t_valid = 1'b1;
            step();
            check($sformatf("thr_b2b%0d_dv", i), t_dv, 1'b1);
            check($sformatf("thr_b2b%0d_data", i), t_odata, (int'(x) > 'h800) ? 1 : 0);
            check($sformatf("thr_b2b%0d_max", i), t_max, x);
            check($sformatf("thr_b2b%0d_ready", i), t_ready, 1'b1);
        end
        t_valid = 1'b0;
        step();
        check("thr_idle_dv", t_dv, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
